// File: rtl/ifid_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue: fetch push side and decode pop side.
// The master modport is the fetch/decode environment; the slave modport is the queue.
interface ifid_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/ifid_queue.sv
// IF/ID instruction queue: circular buffer of {pc, inst} pairs with flush and a NOP head when empty.
// Optional macro IFQ_FULL_PUSH_EN lets a full queue accept a new pair in the same cycle decode pops.
module ifid_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    ifid_queue_if.slave    bus,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wp_reg, wp_next;
    logic [PTR_W-1:0] rp_reg, rp_next;
    logic [PTR_W:0]   cnt_reg, cnt_next;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;

    assign is_full  = (cnt_reg == FULL_CNT);
    assign is_empty = (cnt_reg == '0);

`ifdef IFQ_FULL_PUSH_EN
    // When full, the slot freed by a same-cycle pop is the one being written (wp == rp).
    assign bus.in_ready = ~is_full | bus.out_ready;
`else
    assign bus.in_ready = ~is_full;
`endif

    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = ~is_empty & bus.out_ready & ~flush;

    assign bus.out_valid = ~is_empty;
    assign bus.out_pc    = is_empty ? 32'h0 : pc_mem[rp_reg];
    assign bus.out_inst  = is_empty ? NOP_INST : inst_mem[rp_reg];
    assign count         = cnt_reg;

    always_comb begin
        wp_next  = wp_reg;
        rp_next  = rp_reg;
        cnt_next = cnt_reg;
        if (flush) begin
            wp_next  = '0;
            rp_next  = '0;
            cnt_next = '0;
        end else begin
            if (push) begin
                wp_next = wp_reg + PTR_W'(1);
            end
            if (pop) begin
                rp_next = rp_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_next = cnt_reg + (PTR_W + 1)'(1);
                2'b01:   cnt_next = cnt_reg - (PTR_W + 1)'(1);
                default: cnt_next = cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_reg  <= '0;
            rp_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            wp_reg  <= wp_next;
            rp_reg  <= rp_next;
            cnt_reg <= cnt_next;
        end
    end

    // Entry storage is deliberately left out of reset; out_* masks it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wp_reg]   <= bus.in_pc;
            inst_mem[wp_reg] <= bus.in_inst;
        end
    end

endmodule
